// File: rtl/inst_list_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : inst_list_fetcher
// Purpose  : Fetches a 32-bit instruction list over a 64-bit NASTI read
//            channel and pushes the unpacked words into the instruction FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module inst_list_fetcher #(
  parameter int ADDR_WIDTH = 64,
  parameter int MAX_BURST  = 8,
  parameter int CNT_WIDTH  = 13
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  output logic [ADDR_WIDTH-1:0] ar_addr,
  output logic [7:0]            ar_len,
  output logic [2:0]            ar_size,
  output logic [1:0]            ar_burst,
  output logic                  ar_id,
  output logic                  ar_lock,
  output logic [3:0]            ar_cache,
  output logic [2:0]            ar_prot,
  output logic [3:0]            ar_qos,
  output logic [3:0]            ar_region,
  output logic                  ar_user,
  input  logic                  r_valid,
  output logic                  r_ready,
  input  logic [63:0]           r_data,
  input  logic [1:0]            r_resp,
  input  logic                  r_last,
  output logic                  fifo_w_en,
  output logic [31:0]           fifo_w_data,
  input  logic                  fifo_full
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_WIDTH-1:0]  r_words_left;
  logic [CNT_WIDTH-1:0]  r_beats_left;
  logic [4:0]            r_beat_cnt;
  logic [63:0]           r_hold;
  logic                  r_hold_valid;
  logic                  r_half;
  logic                  r_error;
  logic                  r_discard;

  logic [12:0]           w_to_4k;
  logic [9:0]            w_beats_4k;
  logic [4:0]            w_left_sat;
  logic [4:0]            w_burst;
  logic [CNT_WIDTH-1:0]  w_beats_init;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_fire;
  logic                  w_hold_clr;
  logic                  w_unpack;

  // Beats left before the next 4 KB page; addr is always 8-byte aligned.
  assign w_to_4k    = 13'd4096 - {1'b0, r_addr[11:0]};
  assign w_beats_4k = w_to_4k[12:3];
  assign w_left_sat = (r_beats_left >= CNT_WIDTH'(MAX_BURST)) ? 5'(MAX_BURST)
                                                              : r_beats_left[4:0];
  assign w_burst    = (w_beats_4k >= {5'b00000, w_left_sat}) ? w_left_sat
                                                             : w_beats_4k[4:0];

  assign w_beats_init = (word_count >> 1) + CNT_WIDTH'(word_count[0]);

  assign w_ar_hs    = ar_valid && ar_ready;
  assign w_r_hs     = r_valid && r_ready;
  assign w_unpack   = (r_state == S_DATA) || (r_state == S_DRAIN);
  assign w_fire     = w_unpack && r_hold_valid && !fifo_full && (r_words_left != '0);
  assign w_hold_clr = w_fire && (r_half || (r_words_left == CNT_WIDTH'(1)));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (word_count == '0) ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: begin
        if (w_ar_hs) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_r_hs && (r_beat_cnt == 5'd1)) begin
          w_state_nxt = (r_beats_left != '0) ? S_ADDR : S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave as the last word is written so done follows it directly.
        if (!r_hold_valid || w_hold_clr) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_addr       <= '0;
      r_words_left <= '0;
      r_beats_left <= '0;
      r_beat_cnt   <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_half       <= 1'b0;
      r_error      <= 1'b0;
      r_discard    <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_addr       <= base_addr & ~ADDR_WIDTH'(7);
        r_words_left <= word_count;
        r_beats_left <= w_beats_init;
        r_error      <= 1'b0;
        r_discard    <= 1'b0;
        r_hold_valid <= 1'b0;
        r_half       <= 1'b0;
      end

      if ((r_state == S_ADDR) && w_ar_hs) begin
        r_addr       <= r_addr + ADDR_WIDTH'({w_burst, 3'b000});
        r_beats_left <= r_beats_left - CNT_WIDTH'(w_burst);
        r_beat_cnt   <= w_burst;
      end

      if ((r_state == S_DATA) && w_r_hs) begin
        r_beat_cnt <= r_beat_cnt - 5'd1;
        if (r_last != (r_beat_cnt == 5'd1)) begin
          r_error <= 1'b1;
        end
        // A bad response poisons the rest of the job: beats are drained unused.
        if (r_resp != 2'b00) begin
          r_error   <= 1'b1;
          r_discard <= 1'b1;
        end else if (!r_discard) begin
          r_hold       <= r_data;
          r_hold_valid <= 1'b1;
          r_half       <= 1'b0;
        end
      end

      if (w_fire) begin
        r_words_left <= r_words_left - CNT_WIDTH'(1);
        if (w_hold_clr) begin
          r_hold_valid <= 1'b0;
          r_half       <= 1'b0;
        end else begin
          r_half <= 1'b1;
        end
      end
    end
  end

  assign busy        = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_DRAIN);
  assign done        = (r_state == S_DONE);
  assign error       = r_error;
  assign ar_valid    = (r_state == S_ADDR);
  assign ar_addr     = ar_valid ? r_addr : '0;
  assign ar_len      = ar_valid ? {3'b000, w_burst - 5'd1} : 8'd0;
  assign ar_size     = 3'd3;
  assign ar_burst    = 2'b01;
  assign ar_id       = 1'b0;
  assign ar_lock     = 1'b0;
  assign ar_cache    = 4'd0;
  assign ar_prot     = 3'd0;
  assign ar_qos      = 4'd0;
  assign ar_region   = 4'd0;
  assign ar_user     = 1'b0;
  assign r_ready     = (r_state == S_DATA) && !r_hold_valid;
  assign fifo_w_en   = w_fire;
  assign fifo_w_data = !w_fire ? 32'd0 : (r_half ? r_hold[63:32] : r_hold[31:0]);

endmodule
`default_nettype wire

// File: tb/tb_inst_list_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_list_fetcher
// Purpose  : Directed scoreboard bench with a NASTI read slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_list_fetcher;

  logic        aclk;
  logic        aresetn;
  logic        start;
  logic [63:0] base_addr;
  logic [12:0] word_count;
  logic        busy, done, error;
  logic        ar_valid, ar_ready;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        ar_id, ar_lock, ar_user;
  logic [3:0]  ar_cache, ar_qos, ar_region;
  logic [2:0]  ar_prot;
  logic        r_valid, r_ready, r_last;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        fifo_w_en, fifo_full;
  logic [31:0] fifo_w_data;

  inst_list_fetcher #(.ADDR_WIDTH(64), .MAX_BURST(8), .CNT_WIDTH(13)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .base_addr(base_addr),
    .word_count(word_count), .busy(busy), .done(done), .error(error),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst), .ar_id(ar_id), .ar_lock(ar_lock),
    .ar_cache(ar_cache), .ar_prot(ar_prot), .ar_qos(ar_qos), .ar_region(ar_region),
    .ar_user(ar_user), .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .r_resp(r_resp), .r_last(r_last), .fifo_w_en(fifo_w_en),
    .fifo_w_data(fifo_w_data), .fifo_full(fifo_full)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] mem [logic [63:0]];
  logic [31:0] exp_q [$];
  logic [71:0] ar_q  [$];
  int          n_writes   = 0;
  int          beats_seen = 0;
  int          job_beat   = 0;
  int          err_beat   = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [63:0] mem64(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return {word_at(a + 64'd4), word_at(a)};
  endfunction

  // NASTI read slave plus FIFO-side monitor.
  initial begin : slave
    logic        ar_hs, r_hs, wr;
    logic [31:0] wd;
    logic [63:0] s_addr, a_addr;
    logic [7:0]  a_len;
    logic [71:0] ar_e;
    int          s_rem;
    ar_ready = 1'b1; r_valid = 1'b0; r_data = '0; r_resp = '0; r_last = 1'b0;
    s_addr = '0; s_rem = 0;
    forever begin
      @(negedge aclk);
      ar_hs  = ar_valid && ar_ready;
      r_hs   = r_valid && r_ready;
      a_addr = ar_addr;
      a_len  = ar_len;
      wr     = fifo_w_en;
      wd     = fifo_w_data;
      if (wr) begin
        n_writes++;
        chk("wen_while_full", {63'd0, fifo_full}, 64'd0);
        if (exp_q.size() == 0) chk("spurious_write", 64'd1, 64'd0);
        else chk("fifo_word", {32'd0, wd}, {32'd0, exp_q.pop_front()});
      end
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        ar_ready = 1'b1; r_valid = 1'b0; r_last = 1'b0; r_resp = '0; s_rem = 0;
        continue;
      end
      if (ar_hs) begin
        if (ar_q.size() == 0) chk("unexpected_ar", 64'd1, 64'd0);
        else begin
          ar_e = ar_q.pop_front();
          chk("ar_addr", a_addr, ar_e[71:8]);
          chk("ar_len", {56'd0, a_len}, {56'd0, ar_e[7:0]});
        end
        s_addr = a_addr;
        s_rem  = int'(a_len) + 1;
        ar_ready = 1'b0;
        r_valid  = 1'b1;
      end else if (r_hs) begin
        beats_seen++;
        job_beat++;
        s_addr = s_addr + 64'd8;
        s_rem--;
        if (s_rem == 0) begin
          r_valid  = 1'b0;
          ar_ready = 1'b1;
        end
      end
      if (r_valid) begin
        r_data = mem64(s_addr);
        r_last = (s_rem == 1);
        r_resp = (job_beat == err_beat) ? 2'd2 : 2'd0;
      end
    end
  end

  task automatic push_ar(input logic [63:0] a, input logic [7:0] len);
    ar_q.push_back({a, len});
  endtask

  task automatic run_job(input logic [63:0] base, input int count, input int n_push,
                         input logic exp_err, input int exp_beats);
    logic [63:0] a, m;
    bit got;
    job_beat = 0; beats_seen = 0; n_writes = 0;
    for (int i = 0; i < n_push; i++) begin
      a = (base & ~64'd7) + 64'(4 * i);
      m = mem64(a & ~64'd7);
      exp_q.push_back(a[2] ? m[63:32] : m[31:0]);
    end
    @(posedge aclk); #1;
    start = 1'b1; base_addr = base; word_count = 13'(count);
    @(posedge aclk); #1;
    start = 1'b0;
    if (count == 0) begin
      chk("zero_done_t1", {63'd0, done}, 64'd1);
      chk("zero_no_ar", {63'd0, ar_valid}, 64'd0);
    end else begin
      chk("busy_t1", {63'd0, busy}, 64'd1);
      chk("ar_valid_t1", {63'd0, ar_valid}, 64'd1);
    end
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (done) got = 1;
      else begin @(posedge aclk); #1; end
    end
    chk("done_seen", {63'd0, got}, 64'd1);
    chk("error_at_done", {63'd0, error}, {63'd0, exp_err});
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    @(posedge aclk); #1;
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("write_count", 64'(n_writes), 64'(n_push));
    chk("words_left_over", 64'(exp_q.size()), 64'd0);
    chk("ars_left_over", 64'(ar_q.size()), 64'd0);
    chk("beat_count", 64'(beats_seen), 64'(exp_beats));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit got;
    aresetn = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; fifo_full = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);
    chk("rst_ar_valid", {63'd0, ar_valid}, 64'd0);
    chk("rst_r_ready", {63'd0, r_ready}, 64'd0);
    chk("rst_fifo_w_en", {63'd0, fifo_w_en}, 64'd0);
    aresetn = 1'b1;

    // Basic single burst with known memory contents.
    mem[64'h1000] = 64'h11111111_00000000;
    mem[64'h1008] = 64'h33333333_22222222;
    push_ar(64'h1000, 8'd1);
    run_job(64'h1000, 4, 4, 1'b0, 2);

    // Odd count split into two bursts; low address bits ignored.
    push_ar(64'h4000, 8'd7);
    push_ar(64'h4040, 8'd1);
    run_job(64'h4004, 19, 19, 1'b0, 10);

    // 4 KB page crossing.
    push_ar(64'h1FF0, 8'd1);
    push_ar(64'h2000, 8'd5);
    run_job(64'h1FF0, 16, 16, 1'b0, 8);

    // FIFO backpressure for 10 cycles mid-burst.
    push_ar(64'h6000, 8'd7);
    n_writes = 0;
    fork
      run_job(64'h6000, 16, 16, 1'b0, 8);
      begin
        got = 0;
        for (int i = 0; i < 500 && !got; i++) begin
          @(negedge aclk);
          if (n_writes >= 3) got = 1;
        end
        chk("stall_reached", {63'd0, got}, 64'd1);
        @(posedge aclk); #1;
        fifo_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
          @(negedge aclk);
          chk("stall_fifo_w_en", {63'd0, fifo_w_en}, 64'd0);
        end
        chk("stall_r_ready", {63'd0, r_ready}, 64'd0);
        @(posedge aclk); #1;
        fifo_full = 1'b0;
      end
    join

    // Error response on the second beat of a four-beat job.
    err_beat = 1;
    push_ar(64'h3000, 8'd3);
    run_job(64'h3000, 8, 2, 1'b1, 4);
    err_beat = -1;

    // Zero-length job; also shows error cleared by a new start.
    run_job(64'h8000, 0, 0, 1'b0, 0);

    // Reset during DATA.
    push_ar(64'h7000, 8'd7);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(word_at(64'h7000 + 64'(4 * i)));
    end
    job_beat = 0; beats_seen = 0;
    @(posedge aclk); #1;
    start = 1'b1; base_addr = 64'h7000; word_count = 13'd16;
    @(posedge aclk); #1;
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge aclk);
      if (beats_seen >= 2) got = 1;
    end
    chk("reset_reached_data", {63'd0, got}, 64'd1);
    aresetn = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_ar_valid", {63'd0, ar_valid}, 64'd0);
    chk("midrst_r_ready", {63'd0, r_ready}, 64'd0);
    chk("midrst_fifo_w_en", {63'd0, fifo_w_en}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_ar_len", {56'd0, ar_len}, 64'd0);
    repeat (2) @(posedge aclk);
    exp_q.delete();
    ar_q.delete();
    @(negedge aclk);
    aresetn = 1'b1;

    push_ar(64'h1000, 8'd1);
    run_job(64'h1000, 4, 4, 1'b0, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
